dcache_port_arbiter: RTL

- Shares the single dcache load/store port between the two EXM lanes of the dual-issue core. Replaces the combinational valid-based mux in core_top.
- Lane 0 holds the older instruction and has fixed priority. A grant stays locked through dcache backpressure.
- Tracks the one outstanding load, routes its response back to the owning lane, and drops responses whose lane was cancelled.
- Sits between EXM_stage1/EXM_stage2 and dcache_dummy (later the real dcache).

---
 rtl/dcache_port_arbiter_if.sv | 41 ++++
 rtl/dcache_port_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter_if.sv
// Lane-side and dcache-side handshake bundle for dcache_port_arbiter.
// slave = arbiter view, master = pipeline/dcache environment view.
interface dcache_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              l0_valid, l1_valid;
    logic              l0_op, l1_op;
    logic [ADDR_W-1:0] l0_addr, l1_addr;
    logic              l0_uncached, l1_uncached;
    logic [3:0]        l0_awstrb, l1_awstrb;
    logic [DATA_W-1:0] l0_wdata, l1_wdata;
    logic              l0_cancel, l1_cancel;
    logic              l0_ready, l1_ready;
    logic              l0_rvalid, l1_rvalid;
    logic [DATA_W-1:0] l0_rdata, l1_rdata;

    logic              dc_valid, dc_ready;
    logic              dc_op, dc_uncached;
    logic [ADDR_W-1:0] dc_addr;
    logic [3:0]        dc_awstrb;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_rvalid;
    logic [DATA_W-1:0] dc_rdata;

    modport slave (
        input  l0_valid, l0_op, l0_addr, l0_uncached, l0_awstrb, l0_wdata, l0_cancel,
        input  l1_valid, l1_op, l1_addr, l1_uncached, l1_awstrb, l1_wdata, l1_cancel,
        output l0_ready, l0_rvalid, l0_rdata, l1_ready, l1_rvalid, l1_rdata,
        output dc_valid, dc_op, dc_addr, dc_uncached, dc_awstrb, dc_wdata,
        input  dc_ready, dc_rvalid, dc_rdata
    );

    modport master (
        output l0_valid, l0_op, l0_addr, l0_uncached, l0_awstrb, l0_wdata, l0_cancel,
        output l1_valid, l1_op, l1_addr, l1_uncached, l1_awstrb, l1_wdata, l1_cancel,
        input  l0_ready, l0_rvalid, l0_rdata, l1_ready, l1_rvalid, l1_rdata,
        input  dc_valid, dc_op, dc_addr, dc_uncached, dc_awstrb, dc_wdata,
        output dc_ready, dc_rvalid, dc_rdata
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Shares the dcache port between two EXM lanes, lane 0 fixed priority; optional perf counters via DCACHE_ARB_PERF_EN.
// Latency: grant/ready combinational, same cycle; load response forwarded combinationally to the owning lane.
// Backpressure: grant locked while dc_ready is low; new requests stall while one load is outstanding.
module dcache_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef DCACHE_ARB_PERF_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic aclk,
    input  logic aresetn,
    dcache_port_arbiter_if.slave bus
`ifdef DCACHE_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_l0_accepts,
    output logic [CNT_W-1:0] perf_l1_accepts,
    output logic [CNT_W-1:0] perf_stall_cycles
`endif
);
    typedef enum logic {IDLE, WAIT_RESP} state_t;

    state_t state;
    logic   lock, lock_lane, owner, drop;

    logic [1:0]        req, cancel;
    logic              sel, grant, accept, sel_op, hit_now, owner_cancel, resp_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              l0_rv, l1_rv;

    always_comb begin
        cancel       = {bus.l1_cancel, bus.l0_cancel};
        req          = {bus.l1_valid & ~bus.l1_cancel, bus.l0_valid & ~bus.l0_cancel};
        sel          = lock ? lock_lane : ~req[0];
        grant        = aresetn & (state == IDLE) & req[sel];
        accept       = grant & bus.dc_ready;
        sel_op       = sel ? bus.l1_op : bus.l0_op;
        sel_addr     = sel ? bus.l1_addr : bus.l0_addr;
        sel_wdata    = sel ? bus.l1_wdata : bus.l0_wdata;
        hit_now      = accept & ~sel_op & bus.dc_rvalid;
        owner_cancel = cancel[owner];
        // Cancel seen in the response cycle itself also swallows the data.
        resp_ok      = aresetn & (state == WAIT_RESP) & bus.dc_rvalid & ~drop & ~owner_cancel;
        l0_rv        = (hit_now & ~sel) | (resp_ok & ~owner);
        l1_rv        = (hit_now & sel) | (resp_ok & owner);
    end

    assign bus.dc_valid    = grant;
    assign bus.dc_op       = grant & sel_op;
    assign bus.dc_addr     = grant ? sel_addr : '0;
    assign bus.dc_uncached = grant & (sel ? bus.l1_uncached : bus.l0_uncached);
    assign bus.dc_awstrb   = grant ? (sel ? bus.l1_awstrb : bus.l0_awstrb) : 4'h0;
    assign bus.dc_wdata    = grant ? sel_wdata : '0;
    assign bus.l0_ready    = accept & ~sel;
    assign bus.l1_ready    = accept & sel;
    assign bus.l0_rvalid   = l0_rv;
    assign bus.l1_rvalid   = l1_rv;
    assign bus.l0_rdata    = l0_rv ? bus.dc_rdata : '0;
    assign bus.l1_rdata    = l1_rv ? bus.dc_rdata : '0;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            lock      <= 1'b0;
            lock_lane <= 1'b0;
            owner     <= 1'b0;
            drop      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Lock also falls away when the locked lane stops requesting.
                    lock <= grant & ~bus.dc_ready;
                    if (grant) lock_lane <= sel;
                    if (accept && !sel_op && !bus.dc_rvalid) begin
                        owner <= sel;
                        drop  <= 1'b0;
                        state <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (bus.dc_rvalid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else if (owner_cancel) begin
                        drop  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_ARB_PERF_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            perf_l0_accepts   <= '0;
            perf_l1_accepts   <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (accept && !sel) perf_l0_accepts <= perf_l0_accepts + 1'b1;
            if (accept && sel)  perf_l1_accepts <= perf_l1_accepts + 1'b1;
            if ((req[0] && req[1]) || (state == WAIT_RESP && req != 2'b00))
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
        end
    end
`endif

    a_no_stray_resp: assert property (@(posedge aclk) disable iff (!aresetn)
        (state == IDLE && bus.dc_rvalid) |-> (accept && !sel_op));
endmodule
